// File: rtl/ysyx_23060203_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_23060203_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    // Read-burst owner encoding.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Simulation-only performance counter indices.
    localparam logic [1:0] PERF_ARB_IFU   = 2'd0;
    localparam logic [1:0] PERF_ARB_LSU   = 2'd1;
    localparam logic [1:0] PERF_ARB_STALL = 2'd2;
    localparam int         PERF_NUM       = 3;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle (AR/R/AW/W/B) shared by the arbiter's master-facing and memory-facing ports.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0]   araddr;
    logic [ID_W-1:0]     arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [ID_W-1:0]     rid;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;
    logic                bvalid;
    logic                bready;

    // Slave side: the arbiter receives requests from an upstream master.
    modport in (
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rid, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );

    // Master side: the arbiter drives the memory port.
    modport out (
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rid, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );
endinterface

// File: rtl/ysyx_23060203_rr_pick2.sv
// Two-way read-owner pick: lone requester wins; ties go round-robin or to the LSU.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module ysyx_23060203_rr_pick2
    import ysyx_23060203_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,        // [1]=LSU, [0]=IFU
    input  logic       last_owner,
    output logic       pick
);

    // Resolve the winner for this cycle's request pattern.
    always_comb begin
        pick = OWN_IFU;
        case (req)
            2'b01:   pick = OWN_IFU;
            2'b10:   pick = OWN_LSU;
            2'b11:   pick = RR_EN ? ~last_owner : OWN_LSU;
            default: pick = OWN_IFU;
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_axi_arbiter.sv
// Shares one memory AXI port between IFU (read) and LSU (read+write); one read burst at a time.
// Latency: 1-cycle bubble from master arvalid to memory arvalid; R/AW/W/B pass combinationally.
// Backpressure: non-owner arready held 0; new read grants wait for any outstanding write response.
module ysyx_23060203_axi_arbiter
    import ysyx_23060203_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clock,
    input  logic reset,
    axi_if.in    ifu_r,
    axi_if.in    lsu_r,
    axi_if.in    lsu_w,
    axi_if.out   mem_r,
    axi_if.out   mem_w
);

    rd_state_t rd_state, rd_state_nxt;
    wr_state_t wr_state, wr_state_nxt;
    // Latched on every grant and held until the next one, so it also serves as last_owner.
    logic      owner;
    logic      pick;
    logic      grant;
    logic [1:0] rd_req;
    logic      in_addr, in_data, wr_idle, wr_resp;
    logic      aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic      aw_hs, w_hs, b_hs, ar_hs, r_last_hs;

    assign rd_req  = {lsu_r.arvalid, ifu_r.arvalid};
    assign in_addr = (rd_state == RD_ADDR);
    assign in_data = (rd_state == RD_DATA);
    // Reset gates the forwarded write valids/readies so nothing leaks out while held in reset.
    assign wr_idle = (wr_state == WR_IDLE) & reset;
    assign wr_resp = (wr_state == WR_RESP);

    ysyx_23060203_rr_pick2 #(.RR_EN(RR_EN)) u_pick (
        .req        (rd_req),
        .last_owner (owner),
        .pick       (pick)
    );

    // ---------------- write path (LSU only) ----------------
    assign mem_w.awaddr  = lsu_w.awaddr;
    assign mem_w.awid    = lsu_w.awid;
    assign mem_w.awlen   = lsu_w.awlen;
    assign mem_w.awsize  = lsu_w.awsize;
    assign mem_w.awburst = lsu_w.awburst;
    assign mem_w.wdata   = lsu_w.wdata;
    assign mem_w.wstrb   = lsu_w.wstrb;
    assign mem_w.wlast   = lsu_w.wlast;
    assign lsu_w.bresp   = mem_w.bresp;
    assign lsu_w.bid     = mem_w.bid;

    assign mem_w.awvalid = wr_idle & ~aw_done & lsu_w.awvalid;
    assign lsu_w.awready = wr_idle & ~aw_done & mem_w.awready;
    assign mem_w.wvalid  = wr_idle & ~w_done & lsu_w.wvalid;
    assign lsu_w.wready  = wr_idle & ~w_done & mem_w.wready;
    assign lsu_w.bvalid  = wr_resp & mem_w.bvalid;
    assign mem_w.bready  = wr_resp & lsu_w.bready;

    assign aw_hs = mem_w.awvalid & mem_w.awready;
    assign w_hs  = mem_w.wvalid & mem_w.wready;
    assign b_hs  = mem_w.bvalid & mem_w.bready;

    // Write FSM: collect AW and W in any order, then wait for the single B.
    always_comb begin
        wr_state_nxt = wr_state;
        aw_done_nxt  = aw_done;
        w_done_nxt   = w_done;
        case (wr_state)
            WR_IDLE: begin
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    wr_state_nxt = WR_RESP;
                    aw_done_nxt  = 1'b0;
                    w_done_nxt   = 1'b0;
                end else begin
                    aw_done_nxt  = aw_done | aw_hs;
                    w_done_nxt   = w_done | w_hs;
                end
            end
            WR_RESP: if (b_hs) wr_state_nxt = WR_IDLE;
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    // ---------------- read path ----------------
    // A write handshaking this cycle takes precedence; the read grant retries next cycle.
    assign grant = (rd_state == RD_IDLE) & (|rd_req) & (wr_state == WR_IDLE) & ~aw_hs & ~w_hs;

    assign mem_r.araddr  = (owner == OWN_LSU) ? lsu_r.araddr  : ifu_r.araddr;
    assign mem_r.arid    = (owner == OWN_LSU) ? lsu_r.arid    : ifu_r.arid;
    assign mem_r.arlen   = (owner == OWN_LSU) ? lsu_r.arlen   : ifu_r.arlen;
    assign mem_r.arsize  = (owner == OWN_LSU) ? lsu_r.arsize  : ifu_r.arsize;
    assign mem_r.arburst = (owner == OWN_LSU) ? lsu_r.arburst : ifu_r.arburst;
    assign mem_r.arvalid = in_addr & ((owner == OWN_LSU) ? lsu_r.arvalid : ifu_r.arvalid);
    assign mem_r.rready  = in_data & ((owner == OWN_LSU) ? lsu_r.rready  : ifu_r.rready);

    assign ifu_r.arready = in_addr & (owner == OWN_IFU) & mem_r.arready;
    assign lsu_r.arready = in_addr & (owner == OWN_LSU) & mem_r.arready;
    assign ifu_r.rvalid  = in_data & (owner == OWN_IFU) & mem_r.rvalid;
    assign lsu_r.rvalid  = in_data & (owner == OWN_LSU) & mem_r.rvalid;
    assign ifu_r.rdata   = mem_r.rdata;
    assign ifu_r.rresp   = mem_r.rresp;
    assign ifu_r.rlast   = mem_r.rlast;
    assign ifu_r.rid     = mem_r.rid;
    assign lsu_r.rdata   = mem_r.rdata;
    assign lsu_r.rresp   = mem_r.rresp;
    assign lsu_r.rlast   = mem_r.rlast;
    assign lsu_r.rid     = mem_r.rid;

    assign ar_hs     = mem_r.arvalid & mem_r.arready;
    assign r_last_hs = mem_r.rvalid & mem_r.rready & mem_r.rlast;

    // Read FSM: grant -> forward AR -> stream R until rlast.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (grant)     rd_state_nxt = RD_ADDR;
            RD_ADDR: if (ar_hs)     rd_state_nxt = RD_DATA;
            RD_DATA: if (r_last_hs) rd_state_nxt = RD_IDLE;
            default:                rd_state_nxt = RD_IDLE;
        endcase
    end

    // State, owner and write-progress registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
            owner    <= OWN_IFU;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
            aw_done  <= aw_done_nxt;
            w_done   <= w_done_nxt;
            if (grant) owner <= pick;
        end
    end

    // ---------------- unused channels of each port tie to idle ----------------
    assign ifu_r.awready = 1'b0;
    assign ifu_r.wready  = 1'b0;
    assign ifu_r.bvalid  = 1'b0;
    assign ifu_r.bresp   = '0;
    assign ifu_r.bid     = '0;
    assign lsu_r.awready = 1'b0;
    assign lsu_r.wready  = 1'b0;
    assign lsu_r.bvalid  = 1'b0;
    assign lsu_r.bresp   = '0;
    assign lsu_r.bid     = '0;
    assign lsu_w.arready = 1'b0;
    assign lsu_w.rvalid  = 1'b0;
    assign lsu_w.rdata   = '0;
    assign lsu_w.rresp   = '0;
    assign lsu_w.rlast   = 1'b0;
    assign lsu_w.rid     = '0;
    assign mem_r.awaddr  = '0;
    assign mem_r.awid    = '0;
    assign mem_r.awlen   = '0;
    assign mem_r.awsize  = '0;
    assign mem_r.awburst = '0;
    assign mem_r.awvalid = 1'b0;
    assign mem_r.wdata   = '0;
    assign mem_r.wstrb   = '0;
    assign mem_r.wlast   = 1'b0;
    assign mem_r.wvalid  = 1'b0;
    assign mem_r.bready  = 1'b0;
    assign mem_w.araddr  = '0;
    assign mem_w.arid    = '0;
    assign mem_w.arlen   = '0;
    assign mem_w.arsize  = '0;
    assign mem_w.arburst = '0;
    assign mem_w.arvalid = 1'b0;
    assign mem_w.rready  = 1'b0;

`ifndef SYNTHESIS
    logic [31:0] perf_cnt [0:PERF_NUM-1];
    logic [1:0]  served;
    logic [1:0]  stalled;

    // Requests being served this cycle: a fresh grant, or the owner presenting AR.
    always_comb begin
        served = 2'b00;
        if (grant)        served = (pick  == OWN_LSU) ? 2'b10 : 2'b01;
        else if (in_addr) served = (owner == OWN_LSU) ? 2'b10 : 2'b01;
        stalled = rd_req & ~served;
    end

    // Grant counts per master and per-cycle count of requests held off by arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PERF_NUM; i++) perf_cnt[i] <= '0;
        end else begin
            if (grant && pick == OWN_IFU) perf_cnt[PERF_ARB_IFU] <= perf_cnt[PERF_ARB_IFU] + 32'd1;
            if (grant && pick == OWN_LSU) perf_cnt[PERF_ARB_LSU] <= perf_cnt[PERF_ARB_LSU] + 32'd1;
            perf_cnt[PERF_ARB_STALL] <= perf_cnt[PERF_ARB_STALL]
                                      + 32'(stalled[0]) + 32'(stalled[1]);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060203_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter: round-robin instance (a_*) and fixed-priority instance (b_*).
// Latency: drives at posedge+1, samples at negedge.
// Backpressure: memory side is modelled inline by each scenario task.
module tb_ysyx_23060203_axi_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   aw_cnt = 0;
    int   w_cnt  = 0;

    always #5 clock = ~clock;

    axi_if a_ifu(), a_lsu(), a_lw(), a_mr(), a_mw();
    axi_if b_ifu(), b_lsu(), b_lw(), b_mr(), b_mw();

    ysyx_23060203_axi_arbiter #(.RR_EN(1'b1)) dut (
        .clock (clock), .reset (reset),
        .ifu_r (a_ifu), .lsu_r (a_lsu), .lsu_w (a_lw),
        .mem_r (a_mr),  .mem_w (a_mw)
    );

    ysyx_23060203_axi_arbiter #(.RR_EN(1'b0)) dut_fixed (
        .clock (clock), .reset (reset),
        .ifu_r (b_ifu), .lsu_r (b_lsu), .lsu_w (b_lw),
        .mem_r (b_mr),  .mem_w (b_mw)
    );

    // Memory-side write handshake monitor for the round-robin instance.
    always @(posedge clock) begin
        if (reset && a_mw.awvalid && a_mw.awready) aw_cnt++;
        if (reset && a_mw.wvalid && a_mw.wready)   w_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic mid;
        @(negedge clock);
    endtask

    function automatic logic [11:0] a_outs();
        return {a_mr.arvalid, a_mr.rready, a_mw.awvalid, a_mw.wvalid, a_mw.bready,
                a_ifu.arready, a_lsu.arready, a_ifu.rvalid, a_lsu.rvalid,
                a_lw.awready, a_lw.wready, a_lw.bvalid};
    endfunction

    function automatic logic [5:0] b_outs();
        return {b_mr.arvalid, b_mr.rready, b_ifu.arready, b_lsu.arready,
                b_ifu.rvalid, b_lsu.rvalid};
    endfunction

    task automatic clear_inputs;
        a_ifu.arvalid = 0; a_ifu.araddr = '0; a_ifu.arid = '0; a_ifu.arlen = '0;
        a_ifu.arsize = 3'd2; a_ifu.arburst = 2'b01; a_ifu.rready = 0;
        a_lsu.arvalid = 0; a_lsu.araddr = '0; a_lsu.arid = '0; a_lsu.arlen = '0;
        a_lsu.arsize = 3'd2; a_lsu.arburst = 2'b01; a_lsu.rready = 0;
        a_lw.awvalid = 0; a_lw.awaddr = '0; a_lw.awid = '0; a_lw.awlen = '0;
        a_lw.awsize = 3'd2; a_lw.awburst = 2'b01;
        a_lw.wvalid = 0; a_lw.wdata = '0; a_lw.wstrb = '0; a_lw.wlast = 0; a_lw.bready = 0;
        a_mr.arready = 0; a_mr.rvalid = 0; a_mr.rdata = '0; a_mr.rresp = '0;
        a_mr.rlast = 0; a_mr.rid = '0;
        a_mw.awready = 0; a_mw.wready = 0; a_mw.bvalid = 0; a_mw.bresp = '0; a_mw.bid = '0;
        b_ifu.arvalid = 0; b_ifu.araddr = '0; b_ifu.arid = '0; b_ifu.arlen = '0;
        b_ifu.arsize = 3'd2; b_ifu.arburst = 2'b01; b_ifu.rready = 0;
        b_lsu.arvalid = 0; b_lsu.araddr = '0; b_lsu.arid = '0; b_lsu.arlen = '0;
        b_lsu.arsize = 3'd2; b_lsu.arburst = 2'b01; b_lsu.rready = 0;
        b_lw.awvalid = 0; b_lw.awaddr = '0; b_lw.awid = '0; b_lw.awlen = '0;
        b_lw.awsize = 3'd2; b_lw.awburst = 2'b01;
        b_lw.wvalid = 0; b_lw.wdata = '0; b_lw.wstrb = '0; b_lw.wlast = 0; b_lw.bready = 0;
        b_mr.arready = 0; b_mr.rvalid = 0; b_mr.rdata = '0; b_mr.rresp = '0;
        b_mr.rlast = 0; b_mr.rid = '0;
        b_mw.awready = 0; b_mw.wready = 0; b_mw.bvalid = 0; b_mw.bresp = '0; b_mw.bid = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 0;
        repeat (2) tick();
        @(negedge clock);
        reset = 1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 0;
        a_mr.arready = 1; a_mr.rvalid = 1; a_mr.rlast = 1;
        a_mw.awready = 1; a_mw.wready = 1; a_mw.bvalid = 1;
        a_ifu.rready = 1; a_lsu.rready = 1; a_lw.bready = 1;
        a_ifu.arvalid = 1; a_lsu.arvalid = 1; a_lw.awvalid = 1; a_lw.wvalid = 1;
        b_mr.arready = 1; b_mr.rvalid = 1; b_mr.rlast = 1;
        b_ifu.rready = 1; b_lsu.rready = 1; b_ifu.arvalid = 1; b_lsu.arvalid = 1;
        tick();
        mid();
        checks++;
        if (a_outs() !== 12'h000) begin
            errors++; $display("FAIL reset_outs_rr got %b exp %b", a_outs(), 12'h000);
        end
        checks++;
        if (b_outs() !== 6'h00) begin
            errors++; $display("FAIL reset_outs_fixed got %b exp %b", b_outs(), 6'h00);
        end
    endtask

    task automatic test_ifu_single;
        do_reset();
        a_mr.arready = 1;
        a_ifu.arvalid = 1; a_ifu.araddr = 32'h8000_0000; a_ifu.arlen = 8'd0; a_ifu.arid = 4'h3;
        mid();
        checks++;
        if (a_mr.arvalid !== 1'b0) begin
            errors++; $display("FAIL ifu_bubble got %b exp 0", a_mr.arvalid);
        end
        tick();
        mid();
        checks++;
        if ({a_mr.arvalid, a_ifu.arready, a_lsu.arready} !== 3'b110) begin
            errors++; $display("FAIL ifu_ar_fwd got %b exp 110", {a_mr.arvalid, a_ifu.arready, a_lsu.arready});
        end
        checks++;
        if (a_mr.araddr !== 32'h8000_0000 || a_mr.arid !== 4'h3 || a_mr.arlen !== 8'd0) begin
            errors++; $display("FAIL ifu_ar_fields got %h/%h/%h exp 80000000/3/00", a_mr.araddr, a_mr.arid, a_mr.arlen);
        end
        tick();
        a_ifu.arvalid = 0;
        a_mr.rvalid = 1; a_mr.rdata = 32'h1234_5678; a_mr.rlast = 1; a_mr.rid = 4'h3;
        a_ifu.rready = 1;
        mid();
        checks++;
        if ({a_ifu.rvalid, a_lsu.rvalid, a_mr.rready, a_mr.arvalid} !== 4'b1010) begin
            errors++; $display("FAIL ifu_r_route got %b exp 1010", {a_ifu.rvalid, a_lsu.rvalid, a_mr.rready, a_mr.arvalid});
        end
        checks++;
        if (a_ifu.rdata !== 32'h1234_5678 || a_ifu.rlast !== 1'b1) begin
            errors++; $display("FAIL ifu_rdata got %h/%b exp 12345678/1", a_ifu.rdata, a_ifu.rlast);
        end
        tick();
        a_mr.rvalid = 0;
        mid();
        checks++;
        if ({a_ifu.rvalid, a_mr.rready} !== 2'b00) begin
            errors++; $display("FAIL ifu_r_done got %b exp 00", {a_ifu.rvalid, a_mr.rready});
        end
    endtask

    task automatic test_rr_alternate;
        logic [1:0] exp_g;
        logic [31:0] exp_a;
        do_reset();
        a_mr.arready = 1;
        a_ifu.arvalid = 1; a_ifu.araddr = 32'h8000_1000;
        a_lsu.arvalid = 1; a_lsu.araddr = 32'h8000_2000;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_a = (k % 2 == 0) ? 32'h8000_2000 : 32'h8000_1000;
            mid();
            tick();
            mid();
            checks++;
            if ({a_lsu.arready, a_ifu.arready} !== exp_g) begin
                errors++; $display("FAIL rr_grant%0d got %b exp %b", k, {a_lsu.arready, a_ifu.arready}, exp_g);
            end
            checks++;
            if (a_mr.araddr !== exp_a) begin
                errors++; $display("FAIL rr_addr%0d got %h exp %h", k, a_mr.araddr, exp_a);
            end
            tick();
            a_mr.rvalid = 1; a_mr.rlast = 1; a_ifu.rready = 1; a_lsu.rready = 1;
            mid();
            tick();
            a_mr.rvalid = 0;
        end
    endtask

    task automatic test_fixed_prio;
        do_reset();
        b_mr.arready = 1;
        b_ifu.arvalid = 1; b_ifu.araddr = 32'h8000_3000;
        b_lsu.arvalid = 1; b_lsu.araddr = 32'h8000_4000;
        for (int k = 0; k < 4; k++) begin
            mid();
            tick();
            mid();
            checks++;
            if ({b_lsu.arready, b_ifu.arready} !== 2'b10) begin
                errors++; $display("FAIL fixed_grant%0d got %b exp 10", k, {b_lsu.arready, b_ifu.arready});
            end
            tick();
            b_mr.rvalid = 1; b_mr.rlast = 1; b_ifu.rready = 1; b_lsu.rready = 1;
            mid();
            tick();
            b_mr.rvalid = 0;
        end
        b_lsu.arvalid = 0;
        mid();
        tick();
        mid();
        checks++;
        if ({b_lsu.arready, b_ifu.arready, b_mr.araddr} !== {2'b01, 32'h8000_3000}) begin
            errors++; $display("FAIL fixed_ifu_after got %b/%h exp 01/80003000", {b_lsu.arready, b_ifu.arready}, b_mr.araddr);
        end
    endtask

    task automatic test_store_blocks_read;
        do_reset();
        a_mr.arready = 1; a_mw.awready = 1; a_mw.wready = 1; a_lw.bready = 1;
        a_lw.awvalid = 1; a_lw.awaddr = 32'h8000_0004;
        a_lw.wvalid = 1; a_lw.wdata = 32'hDEAD_BEEF; a_lw.wstrb = 4'b1111; a_lw.wlast = 1;
        a_ifu.arvalid = 1; a_ifu.araddr = 32'h8000_0040;
        mid();
        checks++;
        if ({a_mw.awvalid, a_mw.wvalid, a_lw.awready, a_lw.wready} !== 4'b1111) begin
            errors++; $display("FAIL st_fwd got %b exp 1111", {a_mw.awvalid, a_mw.wvalid, a_lw.awready, a_lw.wready});
        end
        checks++;
        if (a_mw.awaddr !== 32'h8000_0004 || a_mw.wdata !== 32'hDEAD_BEEF || a_mw.wstrb !== 4'hF) begin
            errors++; $display("FAIL st_fields got %h/%h/%h exp 80000004/deadbeef/f", a_mw.awaddr, a_mw.wdata, a_mw.wstrb);
        end
        tick();
        a_lw.awvalid = 0; a_lw.wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            mid();
            checks++;
            if (a_mr.arvalid !== 1'b0) begin
                errors++; $display("FAIL st_wait%0d got arvalid %b exp 0", i, a_mr.arvalid);
            end
            tick();
        end
        a_mw.bvalid = 1; a_mw.bresp = 2'b00;
        mid();
        checks++;
        if ({a_lw.bvalid, a_mw.bready, a_mr.arvalid} !== 3'b110) begin
            errors++; $display("FAIL st_b got %b exp 110", {a_lw.bvalid, a_mw.bready, a_mr.arvalid});
        end
        tick();
        a_mw.bvalid = 0;
        mid();
        checks++;
        if (a_mr.arvalid !== 1'b0) begin
            errors++; $display("FAIL st_grant_cycle got %b exp 0", a_mr.arvalid);
        end
        tick();
        mid();
        checks++;
        if ({a_mr.arvalid, a_ifu.arready, a_mr.araddr} !== {2'b11, 32'h8000_0040}) begin
            errors++; $display("FAIL st_read_after got %b/%h exp 11/80000040", {a_mr.arvalid, a_ifu.arready}, a_mr.araddr);
        end
    endtask

    task automatic test_aw_before_w;
        int aw0, w0;
        do_reset();
        aw0 = aw_cnt; w0 = w_cnt;
        a_mw.awready = 1; a_mw.wready = 1; a_lw.bready = 1;
        a_lw.awvalid = 1; a_lw.awaddr = 32'h8000_0008;
        mid();
        checks++;
        if (a_mw.awvalid !== 1'b1) begin
            errors++; $display("FAIL aw_first got %b exp 1", a_mw.awvalid);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            mid();
            checks++;
            if ({a_mw.awvalid, a_lw.awready} !== 2'b00) begin
                errors++; $display("FAIL aw_mask%0d got %b exp 00", i, {a_mw.awvalid, a_lw.awready});
            end
            tick();
        end
        a_lw.wvalid = 1; a_lw.wdata = 32'hCAFE_F00D; a_lw.wstrb = 4'hF; a_lw.wlast = 1;
        mid();
        checks++;
        if ({a_mw.awvalid, a_mw.wvalid, a_lw.wready, a_mw.bready} !== 4'b0110) begin
            errors++; $display("FAIL w_late got %b exp 0110", {a_mw.awvalid, a_mw.wvalid, a_lw.wready, a_mw.bready});
        end
        tick();
        a_lw.awvalid = 0; a_lw.wvalid = 0;
        mid();
        checks++;
        if ({a_mw.bready, a_lw.awready, a_lw.wready} !== 3'b100) begin
            errors++; $display("FAIL wr_resp_entry got %b exp 100", {a_mw.bready, a_lw.awready, a_lw.wready});
        end
        checks++;
        if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1) begin
            errors++; $display("FAIL hs_count got aw %0d w %0d exp 1 1", aw_cnt - aw0, w_cnt - w0);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        a_mr.arready = 1;
        a_ifu.arvalid = 1; a_ifu.araddr = 32'h8000_0010;
        mid();
        tick();
        mid();
        tick();
        a_ifu.arvalid = 0; a_ifu.rready = 1;
        a_mr.rvalid = 1; a_mr.rlast = 0; a_mr.rdata = 32'h0000_0001;
        mid();
        checks++;
        if (a_ifu.rvalid !== 1'b1) begin
            errors++; $display("FAIL mid_burst_pre got %b exp 1", a_ifu.rvalid);
        end
        #2;
        reset = 0;
        #1;
        checks++;
        if (a_outs() !== 12'h000) begin
            errors++; $display("FAIL async_reset_outs got %b exp %b", a_outs(), 12'h000);
        end
        a_mr.rvalid = 0;
        tick();
        @(negedge clock);
        reset = 1;
        tick();
        a_ifu.arvalid = 1; a_ifu.araddr = 32'h8000_0100;
        mid();
        checks++;
        if (a_mr.arvalid !== 1'b0) begin
            errors++; $display("FAIL post_reset_bubble got %b exp 0", a_mr.arvalid);
        end
        tick();
        mid();
        checks++;
        if ({a_mr.arvalid, a_ifu.arready, a_mr.araddr} !== {2'b11, 32'h8000_0100}) begin
            errors++; $display("FAIL post_reset_grant got %b/%h exp 11/80000100", {a_mr.arvalid, a_ifu.arready}, a_mr.araddr);
        end
    endtask

    initial begin
        test_reset();
        test_ifu_single();
        test_rr_alternate();
        test_fixed_prio();
        test_store_blocks_read();
        test_aw_before_w();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
